// File: rtl/alu_seq_pkg.sv
// Shared opcode/state encodings and opcode-class helpers for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_INC   = 4'h4,
        OP_DEC   = 4'h5,
        OP_XOR   = 4'h6,
        OP_NOT   = 4'h7,
        OP_ADC   = 4'h8,
        OP_SBB   = 4'h9,
        OP_SHL   = 4'hA,
        OP_SHR   = 4'hB,
        OP_SRA   = 4'hC,
        OP_MUL   = 4'hD,
        OP_CMP   = 4'hE,
        OP_PASSB = 4'hF
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic is_add_family(input op_t op);
        return (op == OP_ADD) || (op == OP_INC) || (op == OP_ADC);
    endfunction

    function automatic logic is_sub_family(input op_t op);
        return (op == OP_SUB) || (op == OP_DEC) || (op == OP_SBB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational result/flag generation for every opcode except MUL.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cf,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // INC/DEC share the add/sub paths with a constant-one second operand.
    always_comb begin
        opnd    = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
        cin_ext = {{WIDTH{1'b0}}, ((op == OP_ADC) || (op == OP_SBB)) ? cf : 1'b0};
        sum     = {1'b0, a} + {1'b0, opnd} + cin_ext;
        diff    = {1'b0, a} - {1'b0, opnd} - cin_ext;
    end

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        if (is_add_family(op)) begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (is_sub_family(op)) begin
            result   = diff[WIDTH-1:0];
            carry    = diff[WIDTH];
            overflow = (a[WIDTH-1] != opnd[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end else begin
            case (op)
                OP_AND:   result = a & b;
                OP_OR:    result = a | b;
                OP_XOR:   result = a ^ b;
                OP_NOT:   result = ~a;
                OP_SHL: begin
                    result = {a[WIDTH-2:0], 1'b0};
                    carry  = a[WIDTH-1];
                end
                OP_SHR: begin
                    result = {1'b0, a[WIDTH-1:1]};
                    carry  = a[0];
                end
                OP_SRA: begin
                    result = {a[WIDTH-1], a[WIDTH-1:1]};
                    carry  = a[0];
                end
                OP_PASSB: result = b;
                default:  result = '0;
            endcase
        end
    end

    assign zero     = (result == '0);
    assign negative = result[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, accumulator/stored carry and
// an iterative shift-add multiplier (one partial product per cycle).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t             state, state_next;
    op_t                op_in;
    logic [WIDTH-1:0]   acc, a_eff;
    logic               cf;
    logic               accept, start_mul, mul_done;

    logic [2*WIDTH-1:0] prod, prod_next, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   core_result;
    logic               core_carry, core_zero, core_negative, core_overflow;

    logic               wr_en, wr_acc;
    logic [WIDTH-1:0]   wr_result;
    logic               wr_carry, wr_zero, wr_negative, wr_overflow;

    assign op_in     = op_t'(op);
    assign a_eff     = use_acc ? acc : a;
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign busy      = (state == MUL);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (op_in == OP_MUL);
    assign mul_done  = (state == MUL) && (count == CW'(WIDTH - 1));
    assign prod_next = prod + (mplier[0] ? mcand : '0);

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a        (a_eff),
        .b        (b),
        .cf       (cf),
        .op       (op_in),
        .result   (core_result),
        .carry    (core_carry),
        .zero     (core_zero),
        .negative (core_negative),
        .overflow (core_overflow)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mul) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result write mux: the final multiplier step folds in the last partial product.
    always_comb begin
        wr_en       = (accept && !start_mul) || mul_done;
        wr_acc      = mul_done || (accept && !start_mul && (op_in != OP_CMP));
        wr_result   = core_result;
        wr_carry    = core_carry;
        wr_zero     = core_zero;
        wr_negative = core_negative;
        wr_overflow = core_overflow;
        if (mul_done) begin
            wr_result   = prod_next[WIDTH-1:0];
            wr_carry    = |prod_next[2*WIDTH-1:WIDTH];
            wr_zero     = (prod_next[WIDTH-1:0] == '0);
            wr_negative = prod_next[WIDTH-1];
            wr_overflow = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            acc       <= '0;
            cf        <= 1'b0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            if (wr_en) begin
                out_valid <= 1'b1;
                result    <= wr_result;
                carry     <= wr_carry;
                zero      <= wr_zero;
                negative  <= wr_negative;
                overflow  <= wr_overflow;
            end else if (start_mul || out_ready) begin
                out_valid <= 1'b0;
            end

            if (acc_clr) begin
                acc <= '0;
                cf  <= 1'b0;
            end else if (wr_acc) begin
                acc <= wr_result;
                cf  <= wr_carry;
            end

            if (start_mul) begin
                prod   <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_eff};
                mplier <= b;
                count  <= '0;
            end else if (state == MUL) begin
                prod   <= prod_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
            end
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised-width ALU with valid/ready handshakes on both sides, an internal accumulator and stored carry for multi-word arithmetic, and an iterative shift-add multiplier. It is the sequential successor of the team's 4-bit combinational ALU. The eight base opcodes keep their encodings, widened to a 4-bit opcode space. It sits between an instruction/operand source and a result consumer, either of which may stall.

## Interface
- `WIDTH`, default 8: data width, legal values are 2 or more.
- `clk` in 1: single clock, all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the operation presented on `op`/`a`/`b`/`use_acc` is valid.
- `in_ready` out 1: the block can accept an operation; transfer occurs when `in_valid` and `in_ready` are both high at a rising edge.
- `op` in 4: opcode.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `use_acc` in 1: use the accumulator in place of `a`.
- `acc_clr` in 1: clear the accumulator and the stored carry at the next edge.
- `out_valid` out 1: a result is held on the outputs.
- `out_ready` in 1: the consumer takes the result.
- `result` out WIDTH: operation result.
- `carry`, `zero`, `negative`, `overflow` out 1 each: result flags.
- `busy` out 1: a multiply is in progress.

## Operation
Opcodes and their results:
- 0 ADD: a+b.
- 1 SUB: a−b.
- 2 AND.
- 3 OR.
- 4 INC: a+1.
- 5 DEC: a−1.
- 6 XOR.
- 7 NOT: ~a.
- 8 ADC: a+b+cf.
- 9 SBB: a−b−cf.
- A SHL: a<<1.
- B SHR: logical right shift by 1.
- C SRA: arithmetic right shift by 1.
- D MUL: low WIDTH bits of a×b, unsigned.
- E CMP: computes a−b and sets flags only.
- F PASSB: b.

The effective A operand is `acc` if `use_acc` is high, otherwise `a`. It is captured at the accept edge.

Flag rules:
- `carry` for the add family (ADD, INC, ADC): carry-out.
- `carry` for the subtract family (SUB, DEC, SBB, CMP): borrow, meaning the unsigned A is less than the subtrahend.
- `carry` for shifts: the bit shifted out.
- `carry` for MUL: 1 if any product bit above WIDTH−1 is set.
- `carry` for logic ops and PASSB: 0.
- `overflow`: two's-complement overflow for the add and subtract families; 0 for every other op.
- `zero`: 1 when `result` equals 0.
- `negative`: `result[WIDTH-1]`.
- CMP: `result` carries the difference and all four flags are valid.

Accumulator and stored carry:
- `acc` ← `result` and `cf` ← `carry` whenever a result is written, for every op except CMP.
- `acc_clr` has priority over the accumulator write. The result is still delivered normally.

State machine:
- States are IDLE and MUL.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops: on the accept edge, the result registers are written and `out_valid` is set.
- MUL: on the accept edge the operands and iteration count are loaded, `out_valid` clears, and the state moves to MUL. Iteration i (count 0..WIDTH−1) runs one shift-add step per cycle. On the edge that completes the last iteration, the result is written, `out_valid` is set, and the state returns to IDLE.
- `busy` = (state==MUL).

Output hold:
- While `out_valid` is high and `out_ready` is low, the outputs are stable.
- When `out_ready` is high with no new accept, `out_valid` clears at the edge.

## Timing
- Reset values: state IDLE; `out_valid`, `result`, all four flags, `acc`, `cf` and `busy` are 0. `in_ready` is 1 while `rst_n` is high after reset.
- Single-cycle op latency: accept at edge E, `out_valid` high after E.
- MUL latency: accept at E, `out_valid` high after E+WIDTH. `in_ready` is 0 from after E until the result has been taken.
- Back-to-back: with `out_valid` high, `out_ready` high and a new accept in the same cycle, the old result is consumed and the new one replaces it at the same edge. There are no bubbles for single-cycle ops.
- A combinational path exists from `out_ready` to `in_ready`. No path exists from `in_valid` to `in_ready`.
- ADC/SBB use `cf` and `acc` as they stand at the accept edge, including a value written at the previous edge.
- An `acc_clr` asserted in the same cycle as an accept affects only later ops. The accepted op uses the pre-clear values.
- Reset asserted mid-MUL aborts the multiply immediately. No result is produced.

## Structure
- Package `alu_seq_pkg` holds:
  - the `op_t` enum of 16 opcodes,
  - the `state_t` enum {IDLE, MUL},
  - opcode-class helper functions (is_add_family, is_sub_family).
- Sub-module `alu_seq_core`: purely combinational. It maps A, B, cf and op to result and flags for all non-MUL ops. The top level holds the handshake, the FSM, `acc`/`cf` and the multiplier datapath.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0xFF b=0x01 → `result`=0x00, `carry`=1, `zero`=1, `overflow`=0, `out_valid` high after one edge.
- SUB a=0x80 b=0x01 → 0x7F, `carry`=0, `overflow`=1, `negative`=0. CMP a=0x05 b=0x07 → 0xFE, `carry`=1, `negative`=1, and `acc` is unchanged.
- MUL 0x0D×0x0B → 0x8F, `carry`=0, `negative`=1, `out_valid` exactly 8 edges after accept, `in_ready`=0 and `busy`=1 in between. MUL 0x10×0x10 → 0x00, `carry`=1, `zero`=1.
- Backpressure: `out_ready` low for 3 cycles → outputs frozen, `in_ready`=0. Then `out_ready` and `in_valid` high together → the new result appears at that edge with no gap.
- Chain: ADD 0xF0+0x20 → 0x10, `cf`=1. Then ADC `use_acc`=1 b=0x00 → 0x11. Then SBB `use_acc`=1 b=0x11 → 0x00, `zero`=1. `acc_clr` → a following ADD `use_acc`=1 b=0x03 gives 0x03.
- `rst_n` low during MUL cycle 4 → all outputs 0 at once, no `out_valid`. After release, `in_ready`=1 and the next ADD completes normally.
